// File: rtl/bitrev_reorder_pkg.sv
// Shared FFT definitions: default component width, read-side states and the
// bit-reversal helper used to scatter incoming samples into a bank.
package bitrev_reorder_pkg;

  localparam int FLOAT_PRECISION_DEFAULT = 64;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rd_state_t;

  // Reverses the low 'width' bits of value; bits above width come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < width; i++) begin
      result[i] = value[width-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/bitrev_reorder_pingpong_ram.sv
// Two N-entry banks behind one write port and one registered read port; the
// bank select bit forms the top address bit of a single storage array.
module pingpong_ram #(
  parameter int WIDTH = 128,
  parameter int logn  = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [logn-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [logn-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 << logn;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/bitrev_reorder.sv
// Converts a bit-reversed FFT output stream into natural order using
// ping-pong banks: one bank fills while the other drains without gaps.
module bitrev_reorder
  import bitrev_reorder_pkg::*;
#(
  parameter int FLOAT_PRECISION = FLOAT_PRECISION_DEFAULT,
  parameter int logn            = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [FLOAT_PRECISION-1:0] di_re,
  input  logic [FLOAT_PRECISION-1:0] di_im,
  output logic                       out_valid,
  output logic [FLOAT_PRECISION-1:0] do_re,
  output logic [FLOAT_PRECISION-1:0] do_im,
  output logic [logn-1:0]            out_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int N = 1 << logn;
  localparam logic [logn-1:0] LAST_IDX = logn'(N - 1);

  logic [logn-1:0]              wr_cnt;
  logic [logn-1:0]              wr_addr;
  logic                         wr_bank;
  logic                         swap;
  logic [logn-1:0]              rd_cnt;
  logic [logn-1:0]              rd_cnt_next;
  rd_state_t                    state;
  rd_state_t                    state_next;
  logic                         rd_en;
  logic                         pipe_valid;
  logic [logn-1:0]              pipe_idx;
  logic [2*FLOAT_PRECISION-1:0] rd_data;

  assign swap    = in_valid && (wr_cnt == LAST_IDX);
  assign wr_addr = logn'(bitrev(32'(wr_cnt), logn));
  assign rd_en   = (state == R_DRAIN);
  assign busy    = (wr_cnt != '0) || (state == R_DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      wr_cnt <= wr_cnt + logn'(1);
      if (swap) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= R_IDLE;
      rd_cnt <= '0;
    end else begin
      state  <= state_next;
      rd_cnt <= rd_cnt_next;
    end
  end

  // A freshly completed frame always restarts the drain at index 0; the write
  // side can never finish a frame faster than N cycles, so nothing is cut short.
  always_comb begin
    state_next  = state;
    rd_cnt_next = rd_cnt;
    case (state)
      R_IDLE: begin
      end
      R_DRAIN: begin
        if (rd_cnt == LAST_IDX) begin
          state_next  = R_IDLE;
          rd_cnt_next = '0;
        end else begin
          rd_cnt_next = rd_cnt + logn'(1);
        end
      end
      default: begin
        state_next = R_IDLE;
      end
    endcase
    if (swap) begin
      state_next  = R_DRAIN;
      rd_cnt_next = '0;
    end
  end

  pingpong_ram #(
    .WIDTH(2 * FLOAT_PRECISION),
    .logn (logn)
  ) u_ram (
    .clk    (clk),
    .wr_en  (in_valid),
    .wr_bank(wr_bank),
    .wr_addr(wr_addr),
    .wr_data({di_re, di_im}),
    .rd_en  (rd_en),
    .rd_bank(~wr_bank),
    .rd_addr(rd_cnt),
    .rd_data(rd_data)
  );

  // Index travels alongside the synchronous RAM read so it lines up with data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_idx   <= '0;
    end else begin
      pipe_valid <= rd_en;
      if (rd_en) begin
        pipe_idx <= rd_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      do_re     <= '0;
      do_im     <= '0;
    end else begin
      out_valid <= pipe_valid;
      out_last  <= pipe_valid && (pipe_idx == LAST_IDX);
      if (pipe_valid) begin
        do_re   <= rd_data[2*FLOAT_PRECISION-1:FLOAT_PRECISION];
        do_im   <= rd_data[FLOAT_PRECISION-1:0];
        out_idx <= pipe_idx;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder (logn=3): a frame-level model schedules
// every natural-order output by cycle and a negedge checker compares each cycle.
module tb_bitrev_reorder;

  localparam int FP   = 64;
  localparam int LOGN = 3;
  localparam int N    = 1 << LOGN;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [FP-1:0]   di_re;
  logic [FP-1:0]   di_im;
  logic            out_valid;
  logic [FP-1:0]   do_re;
  logic [FP-1:0]   do_im;
  logic [LOGN-1:0] out_idx;
  logic            out_last;
  logic            busy;

  bitrev_reorder #(
    .FLOAT_PRECISION(FP),
    .logn           (LOGN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .di_re    (di_re),
    .di_im    (di_im),
    .out_valid(out_valid),
    .do_re    (do_re),
    .do_im    (do_im),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cycle;
    logic [63:0] re;
    logic [63:0] im;
    int          idx;
    bit          last;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [63:0] frame_re[$];
  logic [63:0] frame_im[$];
  logic [63:0] last_re = '0;
  logic [63:0] last_im = '0;
  int          last_idx = 0;
  logic [63:0] cap_re[$];
  logic [63:0] cap_im[$];
  int          cap_cyc[$];

  function automatic int rev(input int v, input int bits);
    int r;
    int x;
    r = 0;
    x = v;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Frame model: a completed frame schedules output i (sample rev(i)) two
  // edges after the accepting edge plus i; reset drops everything pending.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      frame_re.delete();
      frame_im.delete();
      exp_q.delete();
      last_re  = '0;
      last_im  = '0;
      last_idx = 0;
    end else if (in_valid) begin
      frame_re.push_back(di_re);
      frame_im.push_back(di_im);
      if (frame_re.size() == N) begin
        for (int i = 0; i < N; i++) begin
          exp_t e;
          e.cycle = cyc + 2 + i;
          e.re    = frame_re[rev(i, LOGN)];
          e.im    = frame_im[rev(i, LOGN)];
          e.idx   = i;
          e.last  = (i == N - 1);
          exp_q.push_back(e);
        end
        frame_re.delete();
        frame_im.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit drain_pending;
      drain_pending = 1'b0;
      foreach (exp_q[j]) begin
        if (exp_q[j].cycle == cyc + 2) drain_pending = 1'b1;
      end
      checkOutput("busy", 64'(busy), 64'((frame_re.size() != 0) || drain_pending));
      if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("out_valid", 64'(out_valid), 64'd1);
        checkOutput("do_re", do_re, e.re);
        checkOutput("do_im", do_im, e.im);
        checkOutput("out_idx", 64'(out_idx), 64'(e.idx));
        checkOutput("out_last", 64'(out_last), 64'(e.last));
        last_re  = e.re;
        last_im  = e.im;
        last_idx = e.idx;
        cap_re.push_back(do_re);
        cap_im.push_back(do_im);
        cap_cyc.push_back(cyc);
      end else begin
        checkOutput("out_valid_idle", 64'(out_valid), 64'd0);
        checkOutput("out_last_idle", 64'(out_last), 64'd0);
        checkOutput("do_re_hold", do_re, last_re);
        checkOutput("do_im_hold", do_im, last_im);
        checkOutput("out_idx_hold", 64'(out_idx), 64'(last_idx));
      end
    end
  end

  task automatic applyStimulus(input bit valid, input logic [63:0] re, input logic [63:0] im);
    @(negedge clk);
    in_valid = valid;
    di_re    = re;
    di_im    = im;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0);
  endtask

  task automatic clearCapture();
    cap_re.delete();
    cap_im.delete();
    cap_cyc.delete();
  endtask

  initial begin
    int  ref_a[8];
    int  ref_b[8];
    int  ref_d[8];
    bit  found;

    ref_a = '{0, 4, 2, 6, 1, 5, 3, 7};
    ref_b = '{8, 12, 10, 14, 9, 13, 11, 15};
    ref_d = '{100, 104, 102, 106, 101, 105, 103, 107};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    di_re    = '0;
    di_im    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_do_re", do_re, 64'd0);
    checkOutput("reset_out_idx", 64'(out_idx), 64'd0);

    $display("[TB] single frame, re=k im=-k");
    clearCapture();
    for (int k = 0; k < N; k++) applyStimulus(1'b1, 64'(k), -64'(k));
    idle(12);
    checkOutput("a_count", 64'(cap_re.size()), 64'd8);
    for (int i = 0; i < 8 && i < cap_re.size(); i++) checkOutput("a_order", cap_re[i], 64'(ref_a[i]));
    if (cap_im.size() > 1) checkOutput("a_im1", cap_im[1], -64'd4);

    $display("[TB] two frames back to back");
    clearCapture();
    for (int k = 0; k < 2 * N; k++) applyStimulus(1'b1, 64'(k), -64'(k));
    idle(12);
    checkOutput("b_count", 64'(cap_re.size()), 64'd16);
    if (cap_re.size() == 16) begin
      for (int i = 0; i < 8; i++) checkOutput("b_frame2", cap_re[8 + i], 64'(ref_b[i]));
      checkOutput("b_contiguous", 64'(cap_cyc[15] - cap_cyc[0]), 64'd15);
    end

    $display("[TB] gapped input");
    clearCapture();
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, 64'(k), -64'(k));
      applyStimulus(1'b0, '0, '0);
    end
    idle(12);
    checkOutput("c_count", 64'(cap_re.size()), 64'd8);
    if (cap_re.size() == 8) begin
      for (int i = 0; i < 8; i++) checkOutput("c_order", cap_re[i], 64'(ref_a[i]));
      checkOutput("c_contiguous", 64'(cap_cyc[7] - cap_cyc[0]), 64'd7);
    end

    $display("[TB] reset discards partial frame");
    clearCapture();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 64'(50 + k), 64'(50 + k));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) applyStimulus(1'b1, 64'(100 + k), 64'(100 + k));
    idle(12);
    checkOutput("d_count", 64'(cap_re.size()), 64'd8);
    for (int i = 0; i < 8 && i < cap_re.size(); i++) checkOutput("d_order", cap_re[i], 64'(ref_d[i]));

    $display("[TB] reset during drain");
    clearCapture();
    for (int k = 0; k < N; k++) applyStimulus(1'b1, 64'(200 + k), 64'(200 + k));
    applyStimulus(1'b0, '0, '0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (out_valid && out_idx == 3'd3) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("e_idx3_seen", 64'(found), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("e_valid_after_reset", 64'(out_valid), 64'd0);
    checkOutput("e_busy_after_reset", 64'(busy), 64'd0);
    idle(12);
    checkOutput("e_count", 64'(cap_re.size()), 64'd4);

    $display("[TB] random data, gapped frames");
    clearCapture();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < N; k++) begin
        applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        idle($urandom_range(0, 2));
      end
    end
    idle(15);
    checkOutput("f_count", 64'(cap_re.size()), 64'd32);
    checkOutput("f_pending", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
